// File: rtl/rvh_uncore_param_pkg.sv
// Shared uncore parameters and types for the 64-bit data burst channel.
// Also holds the state encoding of the receive-side line reassembler.
package rvh_uncore_param_pkg;

  localparam int DATA_LINE_W         = 512;
  localparam int DATA_LENGTH_PER_PKG = 64;
  localparam int DATA_BURST_NUM      = DATA_LINE_W / DATA_LENGTH_PER_PKG;
  localparam int DATA_BURST_NUM_W    = (DATA_BURST_NUM > 1) ? $clog2(DATA_BURST_NUM) : 1;
  localparam int TXN_ID_W            = 4;

  typedef struct packed {
    logic [DATA_LENGTH_PER_PKG-1:0] data;
    logic [DATA_BURST_NUM_W-1:0]    idx;
    logic                           last;
    logic [TXN_ID_W-1:0]            txn_id;
  } data_beat_t;

  typedef struct packed {
    logic [DATA_LINE_W-1:0]    data;
    logic [DATA_BURST_NUM-1:0] mask;
    logic [TXN_ID_W-1:0]       txn_id;
  } data_line_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } deser_state_e;

  // Forces every beat slice whose mask bit is clear to zero.
  function automatic logic [DATA_LINE_W-1:0] zero_fill(
    input logic [DATA_LINE_W-1:0]    data,
    input logic [DATA_BURST_NUM-1:0] mask
  );
    logic [DATA_LINE_W-1:0]    keep;
    logic [DATA_BURST_NUM-1:0] m;
    keep = '0;
    m    = mask;
    for (int k = 0; k < DATA_BURST_NUM; k++) begin
      keep = keep | (DATA_LINE_W'({DATA_LENGTH_PER_PKG{m[0]}}) << (k * DATA_LENGTH_PER_PKG));
      m    = m >> 1;
    end
    return data & keep;
  endfunction

endpackage

// File: rtl/rvh_data_burst_deser_if.sv
// Beat-in / line-out handshake bundle of the data burst reassembler.
// The reassembler is the slave; the beat producer and line consumer form the master.
interface rvh_data_burst_deser_if
  import rvh_uncore_param_pkg::*;
();

  logic                           beat_vld_i;
  logic                           beat_rdy_o;
  logic [DATA_LENGTH_PER_PKG-1:0] beat_data_i;
  logic [DATA_BURST_NUM_W-1:0]    beat_idx_i;
  logic                           beat_last_i;
  logic [TXN_ID_W-1:0]            beat_txn_id_i;
  logic                           line_vld_o;
  logic                           line_rdy_i;
  logic [DATA_LINE_W-1:0]         line_data_o;
  logic [DATA_BURST_NUM-1:0]      line_mask_o;
  logic [TXN_ID_W-1:0]            line_txn_id_o;
  logic                           err_o;

  modport slave (
    input  beat_vld_i, beat_data_i, beat_idx_i, beat_last_i, beat_txn_id_i, line_rdy_i,
    output beat_rdy_o, line_vld_o, line_data_o, line_mask_o, line_txn_id_o, err_o
  );

  modport master (
    output beat_vld_i, beat_data_i, beat_idx_i, beat_last_i, beat_txn_id_i, line_rdy_i,
    input  beat_rdy_o, line_vld_o, line_data_o, line_mask_o, line_txn_id_o, err_o
  );

endinterface

// File: rtl/rvh_data_line_obuf.sv
// One-entry valid/ready output register for assembled lines.
// Slices without a mask bit are stored as zero so consumers never see stale data.
module rvh_data_line_obuf
  import rvh_uncore_param_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       load_i,
  input  data_line_t line_i,
  input  logic       rdy_i,
  output logic       vld_o,
  output data_line_t line_o
);

  logic       vld_q;
  data_line_t line_q;

  // A load may coincide with a drain; the new line simply replaces the old one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q  <= 1'b0;
      line_q <= '0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      line_q <= '{data: zero_fill(line_i.data, line_i.mask), mask: line_i.mask, txn_id: line_i.txn_id};
    end else if (vld_q && rdy_i) begin
      vld_q  <= 1'b0;
    end else begin
      vld_q  <= vld_q;
    end
  end

  assign vld_o  = vld_q;
  assign line_o = line_q;

endmodule

// File: rtl/rvh_data_burst_deser.sv
// Receive-side reassembler: collects 64-bit beats in any order into a 512-bit line
// with a per-beat mask and hands the line out through a one-entry output register.
module rvh_data_burst_deser
  import rvh_uncore_param_pkg::*;
(
  input logic                  clk,
  input logic                  rstn,
  rvh_data_burst_deser_if.slave io
);

  deser_state_e              state_q, state_d;
  logic [DATA_LINE_W-1:0]    buf_data_q, buf_data_d;
  logic [DATA_BURST_NUM-1:0] buf_mask_q, buf_mask_d;
  logic [TXN_ID_W-1:0]       buf_txn_q, buf_txn_d;
  logic                      err_q, err_d;

  data_beat_t                beat_s;
  logic                      accept_s, id_err_s, eff_s, dup_s, complete_s;
  logic                      obuf_free_s, obuf_vld_s, load_s;
  logic [DATA_BURST_NUM-1:0] onehot_s, new_mask_s;
  logic [DATA_LINE_W-1:0]    new_data_s;
  logic [TXN_ID_W-1:0]       cur_txn_s;
  data_line_t                load_line_s, obuf_line_s;

  assign io.beat_rdy_o = (state_q != FULL);

  always_comb begin
    beat_s.data   = io.beat_data_i;
    beat_s.idx    = io.beat_idx_i;
    beat_s.last   = io.beat_last_i;
    beat_s.txn_id = io.beat_txn_id_i;

    accept_s    = io.beat_vld_i && (state_q != FULL);
    id_err_s    = accept_s && (state_q == COLLECT) && (beat_s.txn_id != buf_txn_q);
    eff_s       = accept_s && !id_err_s;
    onehot_s    = DATA_BURST_NUM'(1) << beat_s.idx;
    new_mask_s  = buf_mask_q | onehot_s;
    dup_s       = eff_s && ((buf_mask_q & onehot_s) != '0);
    complete_s  = eff_s && (beat_s.last || (&new_mask_s));
    cur_txn_s   = (state_q == IDLE) ? beat_s.txn_id : buf_txn_q;
    obuf_free_s = !obuf_vld_s || io.line_rdy_i;
    new_data_s  = (buf_data_q & ~(DATA_LINE_W'({DATA_LENGTH_PER_PKG{1'b1}})
                                  << (beat_s.idx * DATA_LENGTH_PER_PKG)))
                | (DATA_LINE_W'(beat_s.data) << (beat_s.idx * DATA_LENGTH_PER_PKG));
    err_d       = id_err_s || dup_s;
  end

  // A completing beat bypasses the buffer when the output register can take it;
  // otherwise the finished line parks in FULL until the consumer drains.
  always_comb begin
    state_d     = state_q;
    buf_data_d  = buf_data_q;
    buf_mask_d  = buf_mask_q;
    buf_txn_d   = buf_txn_q;
    load_s      = 1'b0;
    load_line_s = '{data: buf_data_q, mask: buf_mask_q, txn_id: buf_txn_q};
    case (state_q)
      IDLE, COLLECT: begin
        if (complete_s) begin
          if (obuf_free_s) begin
            load_s      = 1'b1;
            load_line_s = '{data: new_data_s, mask: new_mask_s, txn_id: cur_txn_s};
            state_d     = IDLE;
            buf_data_d  = '0;
            buf_mask_d  = '0;
            buf_txn_d   = '0;
          end else begin
            state_d     = FULL;
            buf_data_d  = new_data_s;
            buf_mask_d  = new_mask_s;
            buf_txn_d   = cur_txn_s;
          end
        end else if (eff_s) begin
          state_d    = COLLECT;
          buf_data_d = new_data_s;
          buf_mask_d = new_mask_s;
          buf_txn_d  = cur_txn_s;
        end else begin
          state_d = state_q;
        end
      end
      FULL: begin
        if (obuf_free_s) begin
          load_s     = 1'b1;
          state_d    = IDLE;
          buf_data_d = '0;
          buf_mask_d = '0;
          buf_txn_d  = '0;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d    = IDLE;
        buf_data_d = '0;
        buf_mask_d = '0;
        buf_txn_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      buf_data_q <= '0;
      buf_mask_q <= '0;
      buf_txn_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_data_q <= buf_data_d;
      buf_mask_q <= buf_mask_d;
      buf_txn_q  <= buf_txn_d;
      err_q      <= err_d;
    end
  end

  rvh_data_line_obuf u_obuf (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (load_s),
    .line_i (load_line_s),
    .rdy_i  (io.line_rdy_i),
    .vld_o  (obuf_vld_s),
    .line_o (obuf_line_s)
  );

  assign io.line_vld_o    = obuf_vld_s;
  assign io.line_data_o   = obuf_line_s.data;
  assign io.line_mask_o   = obuf_line_s.mask;
  assign io.line_txn_id_o = obuf_line_s.txn_id;
  assign io.err_o         = err_q;

endmodule

// File: tb/tb_rvh_data_burst_deser.sv
// Self-checking bench for rvh_data_burst_deser: directed scenarios plus randomized
// bursts, scored against a beat-array reference model and an expected-line queue.
module tb_rvh_data_burst_deser;
  import rvh_uncore_param_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  rvh_data_burst_deser_if bus();

  rvh_data_burst_deser dut (
    .clk  (clk),
    .rstn (rstn),
    .io   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic [7:0]   mask;
    logic [3:0]   txn;
  } exp_line_t;

  int        checks = 0;
  int        errors = 0;
  bit        rand_rdy = 1'b0;
  bit        rdy_fixed = 1'b1;
  exp_line_t exp_q[$];

  // reference model: words and presence flags of the line being gathered
  bit          m_active;
  logic [3:0]  m_txn;
  logic [63:0] m_word [8];
  bit          m_have [8];

  function automatic void model_reset();
    m_active = 1'b0;
    m_txn    = 4'd0;
    for (int k = 0; k < 8; k++) begin
      m_word[3'(k)] = 64'd0;
      m_have[3'(k)] = 1'b0;
    end
    exp_q.delete();
  endfunction

  // returns the expected err_o for this accepted beat
  function automatic bit model_accept(input logic [63:0] d, input logic [2:0] idx,
                                      input logic last, input logic [3:0] txn);
    bit        e;
    int        cnt;
    exp_line_t l;
    if (m_active && txn != m_txn) return 1'b1;
    if (!m_active) begin
      m_active = 1'b1;
      m_txn    = txn;
      for (int k = 0; k < 8; k++) m_have[3'(k)] = 1'b0;
    end
    e           = m_have[idx];
    m_word[idx] = d;
    m_have[idx] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) cnt += m_have[3'(k)] ? 1 : 0;
    if (last || cnt == 8) begin
      l.data = 512'd0;
      l.mask = 8'd0;
      l.txn  = m_txn;
      for (int k = 0; k < 8; k++) begin
        if (m_have[3'(k)]) begin
          l.data = l.data | ({448'd0, m_word[3'(k)]} << (64 * k));
          l.mask = l.mask | (8'd1 << k);
        end
      end
      exp_q.push_back(l);
      m_active = 1'b0;
    end
    return e;
  endfunction

  always begin
    @(posedge clk);
    #2;
    bus.line_rdy_i = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_fixed;
  end

  // scoreboard: every line handed over must match the model's next line
  always @(negedge clk) begin
    #1;
    if (rstn && bus.line_vld_o && bus.line_rdy_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL line_unexpected txn=%h mask=%h", bus.line_txn_id_o, bus.line_mask_o);
      end else begin
        exp_line_t l;
        l = exp_q.pop_front();
        if (bus.line_data_o !== l.data || bus.line_mask_o !== l.mask || bus.line_txn_id_o !== l.txn) begin
          errors++;
          $display("FAIL line_content got txn=%h mask=%h data=%h expected txn=%h mask=%h data=%h",
                   bus.line_txn_id_o, bus.line_mask_o, bus.line_data_o, l.txn, l.mask, l.data);
        end
      end
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [2:0] idx,
                           input logic last, input logic [3:0] txn);
    int w;
    bit exp_err;
    bus.beat_vld_i    = 1'b1;
    bus.beat_data_i   = d;
    bus.beat_idx_i    = idx;
    bus.beat_last_i   = last;
    bus.beat_txn_id_i = txn;
    w = 0;
    while (bus.beat_rdy_o !== 1'b1 && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (w >= 64) begin
      checks++;
      errors++;
      $display("FAIL beat_rdy_timeout idx=%0d got rdy=%b expected 1", idx, bus.beat_rdy_o);
      bus.beat_vld_i = 1'b0;
      return;
    end
    @(posedge clk);
    exp_err = model_accept(d, idx, last, txn);
    @(negedge clk);
    bus.beat_vld_i = 1'b0;
    checks++;
    if (bus.err_o !== exp_err) begin
      errors++;
      $display("FAIL err_pulse idx=%0d txn=%h got %b expected %b", idx, txn, bus.err_o, exp_err);
    end
  endtask

  task automatic set_rdy(input bit r);
    rdy_fixed = r;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.beat_vld_i = 1'b0; bus.beat_data_i = 64'd0; bus.beat_idx_i = 3'd0;
    bus.beat_last_i = 1'b0; bus.beat_txn_id_i = 4'd0; bus.line_rdy_i = 1'b0;
    rstn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.line_vld_o, bus.line_mask_o, bus.line_txn_id_o, bus.err_o} !== 14'd0 || bus.line_data_o !== 512'd0) begin
      errors++;
      $display("FAIL reset_outputs got vld=%b mask=%h txn=%h err=%b expected all zero",
               bus.line_vld_o, bus.line_mask_o, bus.line_txn_id_o, bus.err_o);
    end
    checks++;
    if (bus.beat_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_beat_rdy got %b expected 1", bus.beat_rdy_o);
    end
    rstn = 1'b1;
    set_rdy(1'b1);
  endtask

  task automatic test_in_order();
    for (int k = 0; k < 8; k++) begin
      send_beat(64'((k + 1) * 17), 3'(k), (k == 7), 4'h5);
      if (k == 6) begin
        checks++;
        if (bus.line_vld_o !== 1'b0) begin
          errors++;
          $display("FAIL inorder_early_vld got %b expected 0", bus.line_vld_o);
        end
      end
    end
    checks++;
    if (bus.line_vld_o !== 1'b1 || bus.line_mask_o !== 8'hFF) begin
      errors++;
      $display("FAIL inorder_latency got vld=%b mask=%h expected vld=1 mask=ff", bus.line_vld_o, bus.line_mask_o);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (64'(bus.line_data_o >> (64 * k)) !== 64'((k + 1) * 17)) begin
        errors++;
        $display("FAIL inorder_slice%0d got %h expected %h", k, 64'(bus.line_data_o >> (64 * k)), 64'((k + 1) * 17));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_cwf();
    logic [2:0] order [8];
    order = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    for (int j = 0; j < 8; j++)
      send_beat({$urandom, $urandom}, order[3'(j)], (j == 7), 4'h3);
    checks++;
    if (bus.line_vld_o !== 1'b1 || bus.line_txn_id_o !== 4'h3 || bus.line_mask_o !== 8'hFF) begin
      errors++;
      $display("FAIL cwf_line got vld=%b txn=%h mask=%h expected 1 3 ff", bus.line_vld_o, bus.line_txn_id_o, bus.line_mask_o);
    end
    @(negedge clk);
  endtask

  task automatic test_dirty();
    logic [63:0] d2, d6;
    d2 = {$urandom, $urandom} | 64'd1;
    d6 = {$urandom, $urandom} | 64'd1;
    send_beat(d2, 3'd2, 1'b0, 4'hA);
    send_beat(d6, 3'd6, 1'b1, 4'hA);
    checks++;
    if (bus.line_vld_o !== 1'b1 || bus.line_mask_o !== 8'h44) begin
      errors++;
      $display("FAIL dirty_mask got vld=%b mask=%h expected 1 44", bus.line_vld_o, bus.line_mask_o);
    end
    checks++;
    if (bus.line_data_o !== (({448'd0, d2} << 128) | ({448'd0, d6} << 384))) begin
      errors++;
      $display("FAIL dirty_zero_fill got %h", bus.line_data_o);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    exp_line_t a;
    set_rdy(1'b0);
    for (int k = 0; k < 8; k++) send_beat({$urandom, $urandom}, 3'(k), (k == 7), 4'h6);
    a = exp_q[0];
    for (int k = 0; k < 8; k++) begin
      send_beat({$urandom, $urandom}, 3'(7 - k), (k == 7), 4'h9);
      checks++;
      if (bus.line_vld_o !== 1'b1 || bus.line_data_o !== a.data || bus.line_txn_id_o !== a.txn || bus.line_mask_o !== a.mask) begin
        errors++;
        $display("FAIL bp_hold_a beat%0d got vld=%b txn=%h expected 1 %h", k, bus.line_vld_o, bus.line_txn_id_o, a.txn);
      end
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.beat_rdy_o !== 1'b0 || bus.line_data_o !== a.data || bus.line_txn_id_o !== 4'h6) begin
        errors++;
        $display("FAIL bp_full_stall cycle%0d got rdy=%b txn=%h expected 0 6", c, bus.beat_rdy_o, bus.line_txn_id_o);
      end
      @(negedge clk);
    end
    rdy_fixed = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.line_vld_o !== 1'b1 || bus.line_txn_id_o !== 4'h6 || bus.line_data_o !== a.data) begin
      errors++;
      $display("FAIL bp_a_drain got vld=%b txn=%h expected 1 6", bus.line_vld_o, bus.line_txn_id_o);
    end
    @(negedge clk);
    checks++;
    if (bus.line_vld_o !== 1'b1 || bus.line_txn_id_o !== 4'h9 || bus.line_mask_o !== 8'hFF || bus.beat_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_b_follow got vld=%b txn=%h mask=%h rdy=%b expected 1 9 ff 1",
               bus.line_vld_o, bus.line_txn_id_o, bus.line_mask_o, bus.beat_rdy_o);
    end
    @(negedge clk);
  endtask

  task automatic test_errors();
    logic [63:0] d1;
    d1 = {$urandom, $urandom};
    send_beat({$urandom, $urandom}, 3'd0, 1'b0, 4'h1);
    send_beat({$urandom, $urandom}, 3'd1, 1'b0, 4'h2);
    @(negedge clk);
    checks++;
    if (bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_one_cycle got %b expected 0", bus.err_o);
    end
    send_beat(d1, 3'd0, 1'b0, 4'h1);
    send_beat({$urandom, $urandom}, 3'd7, 1'b1, 4'h1);
    checks++;
    if (bus.line_mask_o !== 8'h81 || 64'(bus.line_data_o) !== d1) begin
      errors++;
      $display("FAIL err_line got mask=%h slice0=%h expected 81 %h", bus.line_mask_o, 64'(bus.line_data_o), d1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    logic [2:0] order [8];
    set_rdy(1'b0);
    for (int k = 0; k < 8; k++) send_beat({$urandom, $urandom}, 3'(k), (k == 7), 4'h7);
    for (int k = 0; k < 3; k++) send_beat({$urandom, $urandom}, 3'(k), 1'b0, 4'h8);
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.line_vld_o !== 1'b0 || bus.line_data_o !== 512'd0 || bus.line_mask_o !== 8'd0 ||
        bus.line_txn_id_o !== 4'd0 || bus.err_o !== 1'b0 || bus.beat_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got vld=%b mask=%h txn=%h rdy=%b expected 0 0 0 1",
               bus.line_vld_o, bus.line_mask_o, bus.line_txn_id_o, bus.beat_rdy_o);
    end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    set_rdy(1'b1);
    for (int k = 0; k < 8; k++) order[3'(k)] = 3'(k);
    for (int k = 7; k > 0; k--) begin
      int r;
      logic [2:0] t;
      r = $urandom_range(0, k);
      t = order[3'(k)]; order[3'(k)] = order[3'(r)]; order[3'(r)] = t;
    end
    for (int j = 0; j < 8; j++) send_beat({$urandom, $urandom}, order[3'(j)], (j == 7), 4'hC);
    checks++;
    if (bus.line_vld_o !== 1'b1 || bus.line_mask_o !== 8'hFF || bus.line_txn_id_o !== 4'hC) begin
      errors++;
      $display("FAIL post_reset_line got vld=%b mask=%h txn=%h expected 1 ff c",
               bus.line_vld_o, bus.line_mask_o, bus.line_txn_id_o);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0] order [8];
    logic [3:0] txn;
    int         n;
    rand_rdy = 1'b1;
    for (int line = 0; line < 40; line++) begin
      txn = 4'($urandom);
      n   = $urandom_range(1, 8);
      for (int k = 0; k < 8; k++) order[3'(k)] = 3'(k);
      for (int k = 7; k > 0; k--) begin
        int r;
        logic [2:0] t;
        r = $urandom_range(0, k);
        t = order[3'(k)]; order[3'(k)] = order[3'(r)]; order[3'(r)] = t;
      end
      for (int j = 0; j < n; j++) begin
        if (j > 0 && $urandom_range(0, 7) == 0)
          send_beat({$urandom, $urandom}, 3'($urandom), 1'($urandom), txn ^ 4'h1);
        if (j > 0 && $urandom_range(0, 7) == 0)
          send_beat({$urandom, $urandom}, order[0], 1'b0, txn);
        send_beat({$urandom, $urandom}, order[3'(j)], (j == n - 1), txn);
      end
    end
    rand_rdy  = 1'b0;
    rdy_fixed = 1'b1;
    for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain got %0d lines outstanding expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_cwf();
    test_dirty();
    test_backpressure();
    test_errors();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
